// File: rtl/game_io_regbank_pkg.sv
// Shared definitions for the processor-to-peripheral register bank.
// Also used by the game logic and renderer for event bits and the game-state code.
package game_io_regbank_pkg;

    // The event status word sits directly after the last data register.
    localparam int EVT_AFTER_REGS = 0;

    localparam int EV_SPACE   = 0;
    localparam int EV_COLLIDE = 1;
    localparam int EV_SCORE   = 2;

    typedef enum logic [1:0] {
        TITLE = 2'd0,
        PLAY  = 2'd1,
        OVER  = 2'd2
    } game_state_e;

    function automatic int evt_addr(input int num_regs);
        return num_regs + EVT_AFTER_REGS;
    endfunction

endpackage

// File: rtl/game_io_regbank_edge_detect_sticky.sv
// Per-bit rising-edge detector feeding sticky status bits with a clear mask.
// A new rising edge beats a clear in the same cycle so no event is lost.
module game_io_regbank_edge_detect_sticky #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] level_in,
    input  logic [WIDTH-1:0] clr_mask,
    output logic [WIDTH-1:0] sticky
);

    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] hist_d;
    logic [WIDTH-1:0] sticky_q;
    logic [WIDTH-1:0] sticky_d;
    logic [WIDTH-1:0] rise;

    always_comb begin
        hist_d   = level_in;
        rise     = level_in & ~hist_q;
        sticky_d = (sticky_q & ~clr_mask) | rise;
    end

    // History loads the live level even in reset so a held-high input
    // does not register as an edge on the first cycle afterwards.
    always_ff @(posedge clock) begin
        hist_q <= hist_d;
        if (reset) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky = sticky_q;

endmodule

// File: rtl/game_io_regbank.sv
// Register bank between the processor and the renderer/game logic, with
// optional frame-synchronous commit and a sticky, clear-on-read event word.
module game_io_regbank
    import game_io_regbank_pkg::*;
#(
    parameter int                NUM_REGS        = 4,
    parameter int                DATA_W          = 16,
    parameter int                ADDR_W          = 6,
    parameter int                NUM_EVENTS      = 4,
    parameter int                COMMIT_ON_FRAME = 1,
    parameter logic [DATA_W-1:0] RESET_VAL       = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    input  logic                       frame_sync,
    input  logic [NUM_EVENTS-1:0]      event_in,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       commit_pulse,
    output logic                       event_pending
);

    localparam logic [ADDR_W-1:0] EVT_ADDR = ADDR_W'(evt_addr(NUM_REGS));

    logic [DATA_W-1:0]     shadow_q [NUM_REGS];
    logic [DATA_W-1:0]     shadow_d [NUM_REGS];
    logic [DATA_W-1:0]     active_q [NUM_REGS];
    logic [DATA_W-1:0]     active_d [NUM_REGS];
    logic [DATA_W-1:0]     rd_data_q;
    logic [DATA_W-1:0]     rd_data_d;
    logic                  rd_valid_q;
    logic                  rd_valid_d;
    logic                  commit_pulse_q;
    logic                  commit_pulse_d;
    logic                  frame_sync_q;
    logic                  frame_rise;
    logic [DATA_W-1:0]     rd_word;
    logic [NUM_EVENTS-1:0] evt_clr;
    logic [NUM_EVENTS-1:0] sticky;

    assign frame_rise = frame_sync & ~frame_sync_q;

    // shadow_d already carries this cycle's write, which gives the
    // same-cycle write forwarding into a commit for free.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            shadow_d[i] = shadow_q[i];
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                shadow_d[i] = wr_data;
            end
            if (COMMIT_ON_FRAME != 0) begin
                active_d[i] = frame_rise ? shadow_d[i] : active_q[i];
            end else begin
                active_d[i] = shadow_d[i];
            end
        end
        commit_pulse_d = frame_rise;
    end

    // Reads see shadow_q, so a same-cycle write to the same address is not visible yet.
    always_comb begin
        rd_word = '0;
        if (rd_addr == EVT_ADDR) begin
            rd_word = DATA_W'(sticky);
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rd_addr == ADDR_W'(i)) begin
                    rd_word = shadow_q[i];
                end
            end
        end
        rd_valid_d = rd_en;
        rd_data_d  = rd_en ? rd_word : rd_data_q;
    end

    always_comb begin
        evt_clr = '0;
        if (rd_en && (rd_addr == EVT_ADDR)) begin
            evt_clr = evt_clr | sticky;
        end
        if (wr_en && (wr_addr == EVT_ADDR)) begin
            evt_clr = evt_clr | wr_data[NUM_EVENTS-1:0];
        end
    end

    always_ff @(posedge clock) begin
        frame_sync_q <= frame_sync;
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= RESET_VAL;
                active_q[i] <= RESET_VAL;
            end
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            commit_pulse_q <= 1'b0;
        end else begin
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
            commit_pulse_q <= commit_pulse_d;
        end
    end

    game_io_regbank_edge_detect_sticky #(
        .WIDTH(NUM_EVENTS)
    ) u_events (
        .clock   (clock),
        .reset   (reset),
        .level_in(event_in),
        .clr_mask(evt_clr),
        .sticky  (sticky)
    );

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[g*DATA_W +: DATA_W] = active_q[g];
    end

    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign commit_pulse  = commit_pulse_q;
    assign event_pending = |sticky;

endmodule

// File: doc/game_io_regbank.md
Name: game_io_regbank

Overview:
- Parametrised processor-to-peripheral register bank, successor to the ad-hoc game_state/bird_y/score strobe registers.
- The processor writes and reads NUM_REGS registers, each DATA_W bits wide, through one address port.
- Values go to the renderer and game logic either immediately or double-buffered and committed on a frame-sync edge, so one VGA frame never shows a torn state.
- Also latches peripheral events (e.g. spacebar, collision) into a sticky status word, read by the processor with clear-on-read.

Parameters:
NUM_REGS, 4, number of output registers (1..32)
DATA_W, 16, width of each register and of the data bus (8..32)
ADDR_W, 6, address width; must satisfy 2**ADDR_W > NUM_REGS+1
NUM_EVENTS, 4, number of event inputs (1..DATA_W)
COMMIT_ON_FRAME, 1, 1 = double-buffered and committed on frame_sync rise; 0 = active output follows write
RESET_VAL, 0, reset value of every shadow and active register

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
wr_en  in  1  write strobe, one transfer per cycle
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_en  in  1  read strobe
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  read data, registered
rd_valid  out  1  one-cycle pulse, 1 cycle after rd_en
frame_sync  in  1  level from the renderer, already synchronised to clock (vsync)
event_in  in  NUM_EVENTS  event levels; a rising edge sets the sticky bit
regs_out  out  NUM_REGS*DATA_W  active registers, reg i at bits [i*DATA_W +: DATA_W]
commit_pulse  out  1  high for one cycle when a frame commit occurs
event_pending  out  1  OR of all sticky event bits

Behaviour:
Clock and reset:
- Clock is clock; reset is reset, synchronous, active-high.
- On reset: all shadow and active registers = RESET_VAL; rd_data = 0; rd_valid = 0; commit_pulse = 0; sticky events = 0.
- The frame_sync and event_in edge-detect history flops load their current inputs, so no edge is detected on the first cycle after reset.

Address map:
- 0..NUM_REGS-1 = data registers.
- EVT = NUM_REGS = event status.
- Any other address: writes are ignored; reads return 0 with rd_valid still pulsed.

Writes:
- Data register with COMMIT_ON_FRAME=1: the shadow register updates at the clock edge. The active register is unchanged until the next commit.
- Data register with COMMIT_ON_FRAME=0: the active register updates at the clock edge; regs_out changes in the next cycle.
- Write to EVT: write-1-to-clear on the sticky bits.

Commit:
- frame_rise = frame_sync & ~frame_sync_q.
- On frame_rise: active <= shadow for all registers, and commit_pulse = 1 in the following cycle.
- A write in the same cycle as frame_rise is forwarded: the committed value is wr_data for that address.
- With COMMIT_ON_FRAME=0, commit_pulse still pulses, but the active registers are unaffected.

Reads:
- Latency 1: rd_data and rd_valid are registered.
- Data address returns the shadow value (the last write), not the active value.
- EVT returns the sticky bits zero-extended to DATA_W, and clears exactly those bits at the same edge.
- When rd_en is low, rd_data holds its previous value and rd_valid = 0.

Events:
- sticky[k] is set on a rising edge of event_in[k].
- Clear-on-read or W1C in the same cycle as a new rising edge of event_in[k]: the set wins, so the bit stays 1 and the event is not lost.
- A level held high does not re-set the bit after a clear.

Simultaneous operations and reset:
- Simultaneous wr_en and rd_en to the same data address: the read returns the old shadow value (read-before-write).
- Reset mid-frame: all state returns to reset values, and any pending shadow values are discarded.

Decomposition:
- Shared package: address-map constants (EVT offset), event-bit indices (EV_SPACE=0, EV_COLLIDE=1, EV_SCORE=2), and the game-state encoding (TITLE=0, PLAY=1, OVER=2), shared with the game logic and renderer.
- One natural sub-module: edge_detect_sticky (per-bit rising-edge detect, sticky set, clear mask, set-priority), instantiated with width NUM_EVENTS.

Test Plan:
- Reset release, COMMIT_ON_FRAME=1, RESET_VAL=0: write reg1=0x00A5 with no frame_sync -> read reg1 = 0x00A5 with rd_valid one cycle later; regs_out[31:16] = 0 until a frame_sync rise, then 0x00A5 one cycle later with commit_pulse=1 for exactly one cycle.
- Write reg2=0x1234 in the exact cycle of the frame_sync rise -> regs_out reg2 = 0x1234 immediately after the commit, not the old value.
- COMMIT_ON_FRAME=0: write reg0=0x0002 -> regs_out[15:0] = 0x0002 on the next cycle with no frame_sync.
- Pulse event_in[0], then read EVT -> 0x0001 and event_pending drops; read EVT again -> 0x0000. Repeat with an event_in[1] rise in the same cycle as the EVT read -> the read returns the old value and bit1 remains set afterwards.
- Write to address NUM_REGS+1 with 0xFFFF -> no register changes; read of the same address returns 0 with rd_valid=1.
- Assert reset after a shadow write but before the commit -> regs_out and the shadow read back RESET_VAL; the next frame_sync commits RESET_VAL.
